karat_32_seq: RTL

KARAT_32_SEQ -- requirements
Module: karat_32_seq

---
 rtl/karat_pkg.sv | 18 +
 rtl/karat_16.sv | 13 +
 rtl/karat_32_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/karat_pkg.sv
// Shared constants for the sequential Karatsuba multiplier.
//   state_e : FSM encoding (IDLE, S_LO, S_HI, S_MID, S_FIN)
//   HALF    : operand half width (16)
//   LATENCY : edges from the accepting edge to the edge that raises done
package karat_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_LO  = 3'd1,
    S_HI  = 3'd2,
    S_MID = 3'd3,
    S_FIN = 3'd4
  } state_e;

  localparam int HALF    = 16;
  localparam int LATENCY = 4;

endpackage

// File: rtl/karat_16.sv
// 16x16 unsigned combinational multiplier.
//   D : multiplicand, 16 bits
//   E : multiplier, 16 bits
//   F : product D*E, 32 bits
module karat_16 (
  input  logic [15:0] D,
  input  logic [15:0] E,
  output logic [31:0] F
);

  assign F = D * E;

endmodule

// File: rtl/karat_32_seq.sv
// Sequential 32x32 unsigned multiplier. One shared 16x16 multiplier is used
// over three passes (z0 = a0*b0, z2 = a1*b1, zm = (a1+a0)*(b1+b0)) and the
// product is recombined Karatsuba-style in a final cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request, sampled only while idle
//   A, B  : operands, captured on the accepting edge
//   busy  : high while an operation is in flight
//   done  : one-cycle pulse, P is new
//   P     : 64-bit product, held until the next completion
module karat_32_seq
  import karat_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] P
);

  generate
    if (W != 32) begin : g_bad_width
      $error("karat_32_seq: only W=32 is supported");
    end
  endgenerate

  state_e             state_q;
  logic [HALF-1:0]    a1_q, a0_q, b1_q, b0_q;
  logic [HALF:0]      sa_q, sb_q;
  logic [2*HALF-1:0]  z0_q, z2_q;
  logic [2*HALF+1:0]  zm_q, zm_d;
  logic [4*HALF-1:0]  p_q, p_d;
  logic               busy_q, done_q;

  logic [HALF-1:0]    mul_d, mul_e;
  logic [2*HALF-1:0]  mul_f;

  // Operand select: every mux input is a register and the select is the
  // registered state, so the multiplier sees only registered values.
  always_comb begin
    mul_d = '0;
    mul_e = '0;
    case (state_q)
      S_LO:    begin mul_d = a0_q;            mul_e = b0_q;            end
      S_HI:    begin mul_d = a1_q;            mul_e = b1_q;            end
      S_MID:   begin mul_d = sa_q[HALF-1:0];  mul_e = sb_q[HALF-1:0];  end
      default: begin mul_d = '0;              mul_e = '0;              end
    endcase
  end

  karat_16 u_mul (
    .D(mul_d),
    .E(mul_e),
    .F(mul_f)
  );

  // The 17-bit sums are multiplied as 16-bit low parts; the carry bits
  // sh/th contribute the missing cross terms and the 2^32 term here.
  always_comb begin
    zm_d = (2*HALF+2)'(mul_f)
         + (sa_q[HALF] ? ((2*HALF+2)'(sb_q[HALF-1:0]) << HALF) : '0)
         + (sb_q[HALF] ? ((2*HALF+2)'(sa_q[HALF-1:0]) << HALF) : '0)
         + ((sa_q[HALF] & sb_q[HALF]) ? ((2*HALF+2)'(1) << (2*HALF)) : '0);
  end

  // zm - z2 - z0 equals a1*b0 + a0*b1, never negative; all terms at 64 bits.
  always_comb begin
    p_d = ((4*HALF)'(z2_q) << (2*HALF))
        + (((4*HALF)'(zm_q) - (4*HALF)'(z2_q) - (4*HALF)'(z0_q)) << HALF)
        + (4*HALF)'(z0_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a1_q    <= '0;
      a0_q    <= '0;
      b1_q    <= '0;
      b0_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      z0_q    <= '0;
      z2_q    <= '0;
      zm_q    <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a1_q    <= A[2*HALF-1:HALF];
            a0_q    <= A[HALF-1:0];
            b1_q    <= B[2*HALF-1:HALF];
            b0_q    <= B[HALF-1:0];
            sa_q    <= {1'b0, A[2*HALF-1:HALF]} + {1'b0, A[HALF-1:0]};
            sb_q    <= {1'b0, B[2*HALF-1:HALF]} + {1'b0, B[HALF-1:0]};
            busy_q  <= 1'b1;
            state_q <= S_LO;
          end
        end
        S_LO: begin
          z0_q    <= mul_f;
          state_q <= S_HI;
        end
        S_HI: begin
          z2_q    <= mul_f;
          state_q <= S_MID;
        end
        S_MID: begin
          zm_q    <= zm_d;
          state_q <= S_FIN;
        end
        S_FIN: begin
          p_q     <= p_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;

endmodule
